mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words in the memory array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between request capture and response; legal range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  1  request strobe from the controller.
REQ-006 SHALL have port we  input  1  write enable (MemWrite); 0 = read.
REQ-007 SHALL have port addr  input  32  byte address; word index = addr[31:2].
REQ-008 SHALL have port wdata  input  32  store data.
REQ-009 SHALL have port rdata  output  32  load data, valid only while ready=1 and we_q=0.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  qualifies ready: access rejected.
REQ-012 SHALL have port busy  output  1  high in BUSY and RESP states; request not accepted.

Function
REQ-013 SHALL implement three states: IDLE, BUSY, RESP.
REQ-014 IDLE with req=1 SHALL capture addr, we, wdata into internal registers and load the wait counter with WAIT_CYCLES.
REQ-015 IDLE->BUSY when req=1 and WAIT_CYCLES>0; IDLE->RESP directly when req=1 and WAIT_CYCLES=0; otherwise stay in IDLE.
REQ-016 BUSY SHALL decrement the counter each cycle and move to RESP in the cycle after the counter reaches 1, giving exactly WAIT_CYCLES cycles in BUSY.
REQ-017 RESP SHALL last exactly one cycle with ready=1, then return to IDLE unconditionally.
REQ-018 Total latency SHALL be WAIT_CYCLES+1 cycles from the capturing edge to the edge that ends the ready pulse.
REQ-019 req, addr, we, wdata changes while busy=1 SHALL be ignored; only the captured values are used.
REQ-020 A new request SHALL be accepted no earlier than the first IDLE cycle after RESP; a req held high through RESP is treated as a new request in that IDLE cycle.
REQ-021 Access SHALL be rejected when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
REQ-022 Rejected access SHALL give err=1 with ready=1, rdata=0, and no array modification.
REQ-023 A good write SHALL update the array on the edge ending RESP; rdata=0 during a write response.
REQ-024 A good read SHALL give rdata = array[captured index] during RESP, reflecting all writes completed before the request.
REQ-025 rdata, ready and err SHALL be 0 in every state except RESP.

Reset
REQ-026 reset=1 SHALL force state IDLE, counter 0, ready=0, err=0, busy=0, rdata=0 and clear the captured registers, on the next rising edge.
REQ-027 reset during BUSY or RESP SHALL abort the access: no ready pulse and no array write, including a write whose RESP edge coincides with reset.
REQ-028 Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-029 State encodings (IDLE=0, BUSY=1, RESP=2), default DEPTH_WORDS and WAIT_CYCLES, and the word-index width SHALL be defined in the shared processor package.
REQ-030 The storage SHALL be a sub-module mem_array: single-port, synchronous-write, combinational-read word RAM, DEPTH_WORDS x 32.

Verification
REQ-031 Reset then write: addr=0x10, wdata=0xDEADBEEF, WAIT_CYCLES=2 -> busy for 3 cycles, ready=1 and err=0 on the 3rd cycle after capture, word 4 = 0xDEADBEEF.
REQ-032 Read back: addr=0x10, we=0 -> rdata=0xDEADBEEF with ready=1 exactly 3 cycles after capture; rdata=0 before and after.
REQ-033 Misaligned and out-of-range: addr=0x11 write 0x1, then addr=0x100 (index 64) read -> each gives ready=1 and err=1, rdata=0; word 4 still 0xDEADBEEF.
REQ-034 Input churn: capture read at 0x10, then drive addr=0x20, we=1 while busy -> response is a read of 0xDEADBEEF; word 8 unchanged.
REQ-035 Reset mid-write: write 0x12345678 to 0x20, assert reset in the BUSY cycle -> no ready pulse, word 8 unchanged, outputs 0 after the reset edge.
REQ-036 WAIT_CYCLES=0 with req held high -> ready pulses every 2nd cycle, back-to-back accesses complete without loss.

Source files
------------

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_responder_pkg : shared types and defaults for the memory responder     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH_WORDS = 64;
  localparam int DEFAULT_WAIT_CYCLES = 2;
  localparam int WORD_IDX_W          = 30;
  localparam int WAIT_CNT_W          = 4;

  // Misaligned byte address, or word index past the end of the array.
  function automatic logic addr_rejected(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_responder_if : request/response bus between controller and responder   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_array : single-port word RAM, synchronous write, combinational read    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  // Guards non-power-of-two depths where addr can exceed the array.
  assign rdata = (32'(addr) < 32'(DEPTH)) ? r_mem[addr] : 32'h0;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_responder : wait-stated word memory slave with error on bad addresses  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  state_t                r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_we;
  logic                  r_bad;
  logic [31:0]           r_wdata;
  logic                  r_ready;
  logic                  r_err;
  logic                  r_busy;
  logic [31:0]           r_rdata;

  logic                  w_in_bad;
  logic [IDX_W-1:0]      w_in_idx;
  logic [IDX_W-1:0]      w_mem_addr;
  logic                  w_mem_we;
  logic [31:0]           w_mem_rdata;

  assign w_in_bad = addr_rejected(bus.addr, DEPTH_WORDS);
  assign w_in_idx = bus.addr[IDX_W+1:2];

  // In IDLE the array is addressed straight from the bus so a zero-wait
  // request can sample its read data on the capturing edge.
  assign w_mem_addr = (r_state == ST_IDLE) ? w_in_idx : r_idx;
  assign w_mem_we   = (r_state == ST_RESP) && r_we && !r_bad && !reset;

  mem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .addr  (w_mem_addr),
    .wdata (r_wdata),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
      r_wdata <= 32'h0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            r_idx   <= w_in_idx;
            r_we    <= bus.we;
            r_bad   <= w_in_bad;
            r_wdata <= bus.wdata;
            r_cnt   <= WAIT_LOAD;
            r_busy  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= ST_RESP;
              r_ready <= 1'b1;
              r_err   <= w_in_bad;
              r_rdata <= (!w_in_bad && !bus.we) ? w_mem_rdata : 32'h0;
            end else begin
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt <= WAIT_CNT_W'(1)) begin
            r_state <= ST_RESP;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_err   <= r_bad;
            r_rdata <= (!r_bad && !r_we) ? w_mem_rdata : 32'h0;
          end else begin
            r_cnt <= r_cnt - WAIT_CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_rdata <= 32'h0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_rdata <= 32'h0;
        end
      endcase
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_responder : self-checking bench, transaction model for two DUTs     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_responder;

  localparam int DEPTH = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_responder_if bus0();
  mem_responder_if bus1();

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;

  // Transaction model: one outstanding access per DUT, timed by cycle numbers.
  bit          pend    [2];
  int          cap     [2];
  bit          c_we    [2];
  bit          c_bad   [2];
  int          c_idx   [2];
  logic [31:0] c_wd    [2];
  logic [31:0] c_rd    [2];
  bit          c_known [2];
  logic [31:0] mmem    [2][DEPTH];
  bit          known   [2][DEPTH];
  bit          e_busy  [2];
  bit          e_ready [2];
  bit          e_err   [2];
  logic [31:0] e_rdata [2];
  bit          e_rknown[2];

  function automatic int waitc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : model
    logic        req_s, we_s;
    logic [31:0] a_s, wd_s;
    bit          was_free;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        req_s = (d == 0) ? bus0.req   : bus1.req;
        we_s  = (d == 0) ? bus0.we    : bus1.we;
        a_s   = (d == 0) ? bus0.addr  : bus1.addr;
        wd_s  = (d == 0) ? bus0.wdata : bus1.wdata;
        if (reset) begin
          pend[d] = 1'b0;
        end else begin
          was_free = !pend[d];
          if (pend[d] && edge_n == cap[d] + waitc(d) + 1) begin
            if (c_we[d] && !c_bad[d]) begin
              mmem[d][c_idx[d]]  = c_wd[d];
              known[d][c_idx[d]] = 1'b1;
            end
            pend[d] = 1'b0;
          end
          if (was_free && req_s) begin
            pend[d]    = 1'b1;
            cap[d]     = edge_n;
            c_we[d]    = we_s;
            c_bad[d]   = (a_s[1:0] != 2'b00) || (int'(a_s[31:2]) >= DEPTH);
            c_idx[d]   = c_bad[d] ? 0 : int'(a_s[31:2]);
            c_wd[d]    = wd_s;
            c_rd[d]    = (c_bad[d] || c_we[d]) ? 32'h0 : mmem[d][c_idx[d]];
            c_known[d] = c_bad[d] || c_we[d] || known[d][c_idx[d]];
          end
        end
        if (pend[d] && edge_n == cap[d] + waitc(d)) begin
          e_busy[d]   = 1'b1;
          e_ready[d]  = 1'b1;
          e_err[d]    = c_bad[d];
          e_rdata[d]  = c_rd[d];
          e_rknown[d] = c_known[d];
        end else begin
          e_busy[d]   = pend[d];
          e_ready[d]  = 1'b0;
          e_err[d]    = 1'b0;
          e_rdata[d]  = 32'h0;
          e_rknown[d] = 1'b1;
        end
      end
      edge_n++;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cycle_dut0",
              64'({bus0.busy, bus0.ready, bus0.err, (e_rknown[0] ? bus0.rdata : 32'h0)}),
              64'({e_busy[0], e_ready[0], e_err[0], (e_rknown[0] ? e_rdata[0] : 32'h0)}));
        check("cycle_dut1",
              64'({bus1.busy, bus1.ready, bus1.err, (e_rknown[1] ? bus1.rdata : 32'h0)}),
              64'({e_busy[1], e_ready[1], e_err[1], (e_rknown[1] ? e_rdata[1] : 32'h0)}));
      end
    end
  end

  // One access on dut0; returns at the negedge of the ready cycle.
  task automatic txn0(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input bit churn, output logic [31:0] rd, output logic er,
                      output int lat, output int nbusy);
    rd = 32'h0; er = 1'b0; lat = 0; nbusy = 0;
    @(negedge clk);
    bus0.req = 1'b1; bus0.addr = a; bus0.we = w; bus0.wdata = wd;
    @(negedge clk);
    if (churn) begin
      bus0.addr = 32'h20; bus0.we = 1'b1; bus0.wdata = 32'hBAD0BAD0;
    end else begin
      bus0.req = 1'b0;
    end
    for (int i = 1; i <= 20; i++) begin
      if (bus0.busy) nbusy++;
      if (bus0.ready) begin
        rd = bus0.rdata; er = bus0.err; lat = i;
        break;
      end
      @(negedge clk);
    end
    bus0.req = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    logic        er;
    int          lat, nb, pulses, consec;
    bit          prev;
    bus0.req = 0; bus0.we = 0; bus0.addr = 0; bus0.wdata = 0;
    bus1.req = 0; bus1.we = 0; bus1.addr = 0; bus1.wdata = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_outputs", 64'({bus0.busy, bus0.ready, bus0.err, bus0.rdata}), 64'h0);
    reset = 1'b0;

    txn0(32'h10, 1'b1, 32'hDEADBEEF, 1'b0, rd, er, lat, nb);
    check("wr_latency", 64'(lat), 64'd3);
    check("wr_busy_cycles", 64'(nb), 64'd3);
    check("wr_err", 64'(er), 64'd0);

    txn0(32'h10, 1'b0, 32'h0, 1'b0, rd, er, lat, nb);
    check("rd_data", 64'(rd), 64'hDEADBEEF);
    check("rd_latency", 64'(lat), 64'd3);
    check("model_rd_pin", 64'(e_rdata[0]), 64'hDEADBEEF);

    txn0(32'h11, 1'b1, 32'h1, 1'b0, rd, er, lat, nb);
    check("misaligned_err_rdata", 64'({er, rd}), 64'({1'b1, 32'h0}));

    txn0(32'h100, 1'b0, 32'h0, 1'b0, rd, er, lat, nb);
    check("range_err_rdata", 64'({er, rd}), 64'({1'b1, 32'h0}));

    txn0(32'h10, 1'b0, 32'h0, 1'b0, rd, er, lat, nb);
    check("word4_intact", 64'(rd), 64'hDEADBEEF);

    txn0(32'h20, 1'b1, 32'hCAFEF00D, 1'b0, rd, er, lat, nb);
    txn0(32'h10, 1'b0, 32'h0, 1'b1, rd, er, lat, nb);
    check("churn_read", 64'({er, rd}), 64'({1'b0, 32'hDEADBEEF}));
    txn0(32'h20, 1'b0, 32'h0, 1'b0, rd, er, lat, nb);
    check("word8_after_churn", 64'(rd), 64'hCAFEF00D);

    // Reset lands in the first BUSY cycle of a write.
    @(negedge clk);
    bus0.req = 1'b1; bus0.addr = 32'h20; bus0.we = 1'b1; bus0.wdata = 32'h12345678;
    @(negedge clk);
    bus0.req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("reset_midwrite_outputs", 64'({bus0.busy, bus0.ready, bus0.err, bus0.rdata}), 64'h0);
    reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus0.ready) pulses++;
    end
    check("reset_no_ready", 64'(pulses), 64'd0);
    txn0(32'h20, 1'b0, 32'h0, 1'b0, rd, er, lat, nb);
    check("word8_after_reset", 64'(rd), 64'hCAFEF00D);

    // Zero-wait responder with req held high: one access every second cycle.
    pulses = 0; consec = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (bus1.ready) pulses++;
        if (bus1.ready && prev) consec++;
        prev = bus1.ready;
      end
      bus1.req = 1'b1; bus1.we = 1'b1;
      bus1.addr = 32'(i % 16) << 2; bus1.wdata = $urandom;
    end
    @(negedge clk);
    bus1.req = 1'b0;
    check("w0_pulses", 64'(pulses), 64'd10);
    check("w0_no_consecutive", 64'(consec), 64'd0);

    // Randomised traffic on both responders, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 2; d++) begin
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 15);
        if (r == 0)      a = ($urandom_range(0, 15) << 2) | 32'($urandom_range(1, 3));
        else if (r == 1) a = 32'($urandom_range(DEPTH, DEPTH + 40)) << 2;
        else             a = 32'($urandom_range(0, 15)) << 2;
        if (d == 0) begin
          bus0.req = ($urandom_range(0, 2) != 0); bus0.we = $urandom_range(0, 1);
          bus0.addr = a; bus0.wdata = $urandom;
        end else begin
          bus1.req = ($urandom_range(0, 2) != 0); bus1.we = $urandom_range(0, 1);
          bus1.addr = a; bus1.wdata = $urandom;
        end
      end
    end
    @(negedge clk);
    reset = 1'b0; bus0.req = 1'b0; bus1.req = 1'b0;
    repeat (6) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
